// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported RAM between the instruction and data
// cache channels. Data has priority. An aging counter bounds how many data grants
// can be taken while an instruction fetch waits.
// Optional build macro MEM_ARB_PERF_EN adds the icount/dcount/stall_cycles counters.
module mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       icount,
    output logic [31:0]       dcount,
    output logic [31:0]       stall_cycles
`endif
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [1:0]  RAM_ACCESS = 2'd2;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic dreq;
    logic access;
    logic starved;
    logic i_done;
    logic d_done;

    assign dreq    = dREN | dWEN;
    assign access  = (ramstate == RAM_ACCESS);
    assign starved = iREN && (starve_q == LIMIT);

    // Completion only counts while the granted requester still asks; ERROR is never a completion.
    assign i_done  = (state_q == IGRANT) && iREN && access;
    assign d_done  = (state_q == DGRANT) && dreq && access;

    // Read data is a plain pass-through; meaningful only in the completion cycle.
    assign iload = ramload;
    assign dload = ramload;

    // Next-state and aging-counter update.
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (dreq && !starved) begin
                    state_d = DGRANT;
                    if (iREN && (starve_q < LIMIT)) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                end else if (iREN) begin
                    state_d  = IGRANT;
                    starve_d = '0;
                end
            end
            IGRANT: begin
                if (!iREN || access) begin
                    state_d = IDLE;
                end
            end
            DGRANT: begin
                if (!dreq || access) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!iREN) begin
            starve_d = '0;
        end
    end

    // State and aging-counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM side and wait signals decode from the registered grant; the requester's
    // enables gate the RAM enables so a withdrawal drops them in the same cycle.
    always_comb begin
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state_q)
            IGRANT: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~i_done;
            end
            DGRANT: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~d_done;
            end
            default: ;
        endcase
    end

`ifdef MEM_ARB_PERF_EN
    logic i_stall;
    logic d_stall;

    assign i_stall = iREN && !i_done;
    assign d_stall = dreq && !d_done;

    // Wrapping performance counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            icount       <= '0;
            dcount       <= '0;
            stall_cycles <= '0;
        end else begin
            if (i_done) begin
                icount <= icount + 32'd1;
            end
            if (d_done) begin
                dcount <= dcount + 32'd1;
            end
            if (i_stall || d_stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequential arbiter that shares the single-ported RAM between the instruction-cache and data-cache request channels.
- Registers a grant and holds it until the RAM reports completion, then re-arbitrates.
- Default priority is data over instruction; an aging counter keeps instruction fetch from being starved.
- Sits between the caches block and the RAM model.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, word width
- STARVE_LIMIT, 4, consecutive data grants allowed while iREN is pending; range 1..15

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  instruction read request
- iaddr  in  ADDR_W  instruction address
- iwait  out  1  instruction stall; 0 only in the completion cycle
- iload  out  DATA_W  instruction read data
- dREN  in  1  data read request
- dWEN  in  1  data write request; wins over dREN if both are high
- daddr  in  ADDR_W  data address
- dstore  in  DATA_W  data write value
- dwait  out  1  data stall; 0 only in the completion cycle
- dload  out  DATA_W  data read data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Clock and reset: one clock, CLK. Reset nRST is asynchronous and active-low.
- Reset values:
  - state=IDLE, starve_cnt=0.
  - iwait=1, dwait=1.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- FSM states: IDLE, IGRANT, DGRANT. The state is registered; all RAM outputs decode from the registered state.
- IDLE:
  - No RAM enables asserted.
  - iwait=dwait=1.
  - Next state: DGRANT if (dREN|dWEN) and not starved; else IGRANT if iREN; else IDLE.
  - "Starved" means iREN=1 and starve_cnt==STARVE_LIMIT. When starved and both channels request, go to IGRANT.
- DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN&~dWEN.
  - When ramstate==ACCESS: dwait=0 combinationally in that cycle, dload=ramload, next state=IDLE.
  - Otherwise dwait=1.
- IGRANT:
  - ramaddr=iaddr, ramREN=1, ramWEN=0.
  - When ramstate==ACCESS: iwait=0 combinationally, iload=ramload, next state=IDLE.
- Wait signals of the non-granted channel are always 1.
- dload and iload pass ramload through unconditionally; they are valid only in the completion cycle.
- Latency: 1 arbitration cycle (IDLE) plus the RAM latency. There is always one IDLE bubble between back-to-back transactions.
- Requester withdrawal: if the granted channel's enables all go low before ACCESS, return to IDLE next cycle. RAM enables drop in that same cycle and no wait pulse is issued.
- ERROR:
  - Treated as not complete: wait stays 1 and the grant is held.
  - The requester or reset must resolve it.
  - ERROR is never converted to a completion.
- starve_cnt (4-bit, saturating at STARVE_LIMIT):
  - Increments on each IDLE→DGRANT transition while iREN=1.
  - Clears on IDLE→IGRANT, or in any cycle with iREN=0.
- Address and data changes mid-grant propagate combinationally to the RAM outputs. Requesters must hold them stable.
- Reset mid-transaction: everything returns to reset values immediately. The aborted transaction produces no completion.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- When defined, three additional output ports are present, all 32-bit wrapping counters, cleared by nRST:
  - icount: incremented per instruction completion.
  - dcount: incremented per data completion.
  - stall_cycles: incremented every cycle a channel requests but is not in its completion cycle.
- When undefined, these ports and registers are absent and behaviour is otherwise identical.

Test Plan:
- Reset with iREN=1 asserted; release nRST; RAM returns ACCESS after 2 BUSY cycles, ramload=0x2402000A.
  -> ramREN=1, ramaddr=iaddr from cycle 1; iwait=0 for exactly one cycle with iload=0x2402000A; then IDLE.
- dWEN=1, dREN=1, daddr=0x80, dstore=0xDEADBEEF.
  -> ramWEN=1, ramREN=0, ramaddr=0x80, ramstore=0xDEADBEEF; dwait=0 on the ACCESS cycle; iwait stays 1 throughout.
- iREN and dREN held high continuously, STARVE_LIMIT=4, RAM ACCESS with 1-cycle latency.
  -> grant order D,D,D,D,I,D,D,D,D,I; an IDLE cycle separates every grant.
- Start a dREN grant, hold ramstate=BUSY, drop dREN after 3 cycles.
  -> ramREN=0 the same cycle; IDLE next cycle; dwait never 0; a pending iREN is granted next.
- Hold ramstate=ERROR during a DGRANT for 5 cycles.
  -> dwait=1 and the grant is held for all 5; ramstate=ACCESS on the next cycle then completes normally.
- Assert nRST=0 mid-DGRANT, asynchronously between clock edges.
  -> ramREN, ramWEN and ramaddr go to 0 immediately, iwait=dwait=1; after release the arbiter starts in IDLE with starve_cnt=0.
